// File: rtl/nw_pkg.sv
// nw_pkg: pointer/state enums, output fill characters and the max3 tie-break shared by nw_align_stream
package nw_pkg;

    typedef enum logic [1:0] {DIAG = 2'd0, UP = 2'd1, LEFT = 2'd2} ptr_t;

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, DP, TRACE, PAD, DONE} state_t;

    localparam logic [7:0] DASH_C       = 8'd45;
    localparam logic [7:0] UNDERSCORE_C = 8'd95;

    // Up beats left only when strictly greater; diag beats that winner only when strictly greater
    function automatic ptr_t nw_max3(input int diag, input int up, input int left);
        int best;
        best = (up > left) ? up : left;
        return (diag > best) ? DIAG : ((up > left) ? UP : LEFT);
    endfunction

endpackage

// File: rtl/nw_cell.sv
// nw_cell: combinational score and traceback pointer for one Needleman-Wunsch cell
module nw_cell import nw_pkg::*; #(
    parameter int CW = 8,
    parameter int SW = 16
) (
    input  logic [CW-1:0]        a_ch,
    input  logic [CW-1:0]        b_ch,
    input  logic signed [SW-1:0] diag,
    input  logic signed [SW-1:0] up,
    input  logic signed [SW-1:0] left,
    input  logic signed [SW-1:0] match_sc,
    input  logic signed [SW-1:0] mism_sc,
    input  logic signed [SW-1:0] gap_sc,
    output logic signed [SW-1:0] score,
    output ptr_t                 ptr
);

    logic signed [SW-1:0] d, u, l;

    // Candidate scores from the three predecessors, then pick the winner
    always_comb begin
        d     = diag + ((a_ch == b_ch) ? match_sc : mism_sc);
        u     = up + gap_sc;
        l     = left + gap_sc;
        ptr   = nw_max3(int'(d), int'(u), int'(l));
        score = (ptr == DIAG) ? d : ((ptr == UP) ? u : l);
    end

endmodule

// File: rtl/nw_align_stream.sv
// nw_align_stream: streaming Needleman-Wunsch global aligner (rolling-row DP, 2-bit pointer RAM traceback).
// Optional macro NW_SCORE_OUT_EN adds the final_score output.
module nw_align_stream import nw_pkg::*; #(
    parameter int ALEN = 16,
    parameter int BLEN = 16,
    parameter int CW   = 8,
    parameter int SW   = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [7:0]    match_sc,
    input  logic [7:0]    mism_sc,
    input  logic [7:0]    gap_sc,
    input  logic          seq_valid,
    output logic          seq_ready,
    input  logic [CW-1:0] seq_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_a,
    output logic [CW-1:0] out_b,
    output logic          out_last,
    output logic          busy,
    output logic          done
`ifdef NW_SCORE_OUT_EN
    ,
    output logic signed [SW-1:0] final_score
`endif
);

    localparam int AW   = $clog2(ALEN + 1);
    localparam int BW   = $clog2(BLEN + 1);
    localparam int PW   = $clog2((ALEN + 1) * (BLEN + 1));
    localparam int TOT  = ALEN + BLEN;
    localparam int CNTW = $clog2(TOT + 1);

    state_t               state, state_nx;
    logic signed [SW-1:0] match_r, mism_r, gap_r, diag_r, cell_sc;
    logic signed [SW-1:0] row [0:ALEN];
    logic [CW-1:0]        seq_a [0:ALEN];
    logic [CW-1:0]        seq_b [0:BLEN];
    ptr_t                 ptr_ram [0:(ALEN+1)*(BLEN+1)-1];
    logic [AW-1:0]        ia, ia_m1, ia_nx;
    logic [BW-1:0]        ib, ib_m1, ib_nx;
    logic [CNTW-1:0]      cnt;
    logic [PW-1:0]        addr;
    ptr_t                 cell_ptr, tr_ptr;
    logic                 seq_hs, load_ok, dp_end, tr_diag, tr_left, tr_end;

    // ia/ib index the current DP cell and, after the fill, the traceback position
    assign ia_m1   = ia - AW'(1);
    assign ib_m1   = ib - BW'(1);
    assign addr    = PW'(ib) * PW'(ALEN + 1) + PW'(ia);
    assign tr_ptr  = ptr_ram[addr];
    assign seq_hs  = seq_valid && seq_ready;
    assign load_ok = !out_valid || out_ready;
    assign dp_end  = state == DP && ib == BW'(BLEN) && ia == AW'(ALEN);

    nw_cell #(.CW(CW), .SW(SW)) u_cell (
        .a_ch     (seq_a[ia_m1]),
        .b_ch     (seq_b[ib_m1]),
        .diag     (diag_r),
        .up       (row[ia]),
        .left     (row[ia_m1]),
        .match_sc (match_r),
        .mism_sc  (mism_r),
        .gap_sc   (gap_r),
        .score    (cell_sc),
        .ptr      (cell_ptr)
    );

    // Traceback step decode; row 0 / column 0 never consult the RAM
    always_comb begin
        tr_diag = tr_ptr == DIAG && ia != '0 && ib != '0;
        tr_left = !tr_diag && ia != '0 && (tr_ptr == LEFT || ib == '0);
        ia_nx   = ia - AW'(tr_diag || tr_left);
        ib_nx   = ib - BW'(!tr_left);
        tr_end  = ia_nx == '0 && ib_nx == '0;
    end

    // State register
    always_ff @(posedge clk) state <= !rstn ? IDLE : state_nx;

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD_A;
            LOAD_A:  if (seq_hs && ia == AW'(ALEN - 1)) state_nx = LOAD_B;
            LOAD_B:  if (seq_hs && ib == BW'(BLEN - 1)) state_nx = DP;
            DP:      if (dp_end) state_nx = TRACE;
            TRACE:   if (load_ok && tr_end) state_nx = PAD;
            PAD:     if (cnt == CNTW'(TOT) && out_valid && out_ready) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        seq_ready = state == LOAD_A || state == LOAD_B;
        busy      = state != IDLE;
        done      = state == DONE;
    end

    // Pointer RAM: one write per interior DP cell
    always_ff @(posedge clk) if (state == DP && ib != '0 && ia != '0) ptr_ram[addr] <= cell_ptr;

    // Datapath: config latch, sequence load, rolling-row DP fill and output pair register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_last  <= 1'b0;
            ia        <= '0;
            ib        <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    match_r <= SW'($signed(match_sc));
                    mism_r  <= SW'($signed(mism_sc));
                    gap_r   <= SW'($signed(gap_sc));
                    ia      <= '0;
                    ib      <= '0;
                    cnt     <= '0;
                end
                LOAD_A: if (seq_hs) begin
                    seq_a[ia] <= seq_data;
                    ia        <= (ia == AW'(ALEN - 1)) ? '0 : ia + AW'(1);
                end
                LOAD_B: if (seq_hs) begin
                    seq_b[ib] <= seq_data;
                    ib        <= (ib == BW'(BLEN - 1)) ? '0 : ib + BW'(1);
                end
                DP: if (ib == '0) begin
                    for (int i = 0; i <= ALEN; i++) row[i] <= SW'(i) * gap_r;
                    ib <= BW'(1);
                end else if (ia == '0) begin
                    diag_r <= row[0];
                    row[0] <= row[0] + gap_r;
                    ia     <= AW'(1);
                end else begin
                    row[ia] <= cell_sc;
                    diag_r  <= row[ia];
                    if (ia != AW'(ALEN)) ia <= ia + AW'(1);
                    else if (ib != BW'(BLEN)) begin
                        ia <= '0;
                        ib <= ib + BW'(1);
                    end
                end
                TRACE: if (load_ok) begin
                    out_valid <= 1'b1;
                    out_a     <= (tr_diag || tr_left) ? seq_a[ia_m1] : CW'(DASH_C);
                    out_b     <= tr_left ? CW'(DASH_C) : seq_b[ib_m1];
                    out_last  <= cnt == CNTW'(TOT - 1);
                    cnt       <= cnt + CNTW'(1);
                    ia        <= ia_nx;
                    ib        <= ib_nx;
                end
                PAD: if (load_ok) begin
                    out_valid <= cnt != CNTW'(TOT);
                    out_last  <= cnt == CNTW'(TOT - 1);
                    if (cnt != CNTW'(TOT)) begin
                        out_a <= CW'(UNDERSCORE_C);
                        out_b <= CW'(UNDERSCORE_C);
                        cnt   <= cnt + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NW_SCORE_OUT_EN
    // M[ALEN][BLEN] captured as the last cell is computed
    always_ff @(posedge clk) begin
        if (!rstn) final_score <= '0;
        else if (dp_end) final_score <= cell_sc;
    end
`endif

endmodule

// File: tb/tb_nw_align_stream.sv
// tb_nw_align_stream: randomized self-checking bench with a full-matrix NW reference model (4x4 and 2x2 instances)
module tb_nw_align_stream;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, seq_valid = 1'b0, out_ready = 1'b0, sel = 1'b0;
  logic [7:0] match_sc = '0, mism_sc = '0, gap_sc = '0, seq_data = '0;
  logic r4, v4, l4, busy4, done4, r2, v2, l2, busy2, done2;
  logic [7:0] a4, b4, a2, b2;
  logic sr, ov, ol, bz, dn;
  logic [7:0] oa, ob;
`ifdef NW_SCORE_OUT_EN
  logic signed [15:0] fs4, fs2, fs;
`endif
  int errors = 0, checks = 0;
  int n, ms, mm, gs, exp_sc;
  logic [7:0] sa [4];
  logic [7:0] sb [4];
  logic [7:0] exp_a [8];
  logic [7:0] exp_b [8];

  always #5 clk = ~clk;

  nw_align_stream #(.ALEN(4), .BLEN(4), .CW(8), .SW(16)) u4 (
    .clk(clk), .rstn(rstn), .start(start && !sel), .match_sc(match_sc), .mism_sc(mism_sc),
    .gap_sc(gap_sc), .seq_valid(seq_valid && !sel), .seq_ready(r4), .seq_data(seq_data),
    .out_valid(v4), .out_ready(out_ready), .out_a(a4), .out_b(b4), .out_last(l4),
    .busy(busy4), .done(done4)
`ifdef NW_SCORE_OUT_EN
    , .final_score(fs4)
`endif
  );

  nw_align_stream #(.ALEN(2), .BLEN(2), .CW(8), .SW(16)) u2 (
    .clk(clk), .rstn(rstn), .start(start && sel), .match_sc(match_sc), .mism_sc(mism_sc),
    .gap_sc(gap_sc), .seq_valid(seq_valid && sel), .seq_ready(r2), .seq_data(seq_data),
    .out_valid(v2), .out_ready(out_ready), .out_a(a2), .out_b(b2), .out_last(l2),
    .busy(busy2), .done(done2)
`ifdef NW_SCORE_OUT_EN
    , .final_score(fs2)
`endif
  );

  assign sr = sel ? r2 : r4;
  assign ov = sel ? v2 : v4;
  assign oa = sel ? a2 : a4;
  assign ob = sel ? b2 : b4;
  assign ol = sel ? l2 : l4;
  assign bz = sel ? busy2 : busy4;
  assign dn = sel ? done2 : done4;
`ifdef NW_SCORE_OUT_EN
  assign fs = sel ? fs2 : fs4;
`endif

  function automatic void model();
    int m [5][5];
    int p [5][5];
    int a, b, d, u, l, k;
    for (int i = 0; i <= n; i++) m[0][i] = i * gs;
    for (int j = 1; j <= n; j++) begin
      m[j][0] = j * gs;
      for (int i = 1; i <= n; i++) begin
        d = m[j-1][i-1] + ((sa[i-1] == sb[j-1]) ? ms : mm);
        u = m[j-1][i] + gs;
        l = m[j][i-1] + gs;
        if (d > u && d > l) begin m[j][i] = d; p[j][i] = 0; end
        else if (u > l) begin m[j][i] = u; p[j][i] = 1; end
        else begin m[j][i] = l; p[j][i] = 2; end
      end
    end
    exp_sc = m[n][n];
    a = n; b = n; k = 0;
    while (a > 0 || b > 0) begin
      if (a > 0 && b > 0 && p[b][a] == 0) begin
        exp_a[k] = sa[a-1]; exp_b[k] = sb[b-1]; a--; b--;
      end else if (a > 0 && (b == 0 || p[b][a] == 2)) begin
        exp_a[k] = sa[a-1]; exp_b[k] = 8'd45; a--;
      end else begin
        exp_a[k] = 8'd45; exp_b[k] = sb[b-1]; b--;
      end
      k++;
    end
    for (; k < 2 * n; k++) begin exp_a[k] = 8'd95; exp_b[k] = 8'd95; end
  endfunction

  task automatic set_job(input bit s, input string a, input string b, input int m1, input int m2, input int g);
    sel = s; n = a.len(); ms = m1; mm = m2; gs = g;
    for (int i = 0; i < n; i++) begin sa[i] = a[i]; sb[i] = b[i]; end
  endtask

  task automatic run_job(input string name, input bit stall, input bit poke, input int abort);
    int idx, cyc, got_done;
    bit acc, pv, pr, pl;
    logic [7:0] pa, pb;
    model();
    match_sc = 8'(ms); mism_sc = 8'(mm); gap_sc = 8'(gs);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 2 * n && cyc < 200) begin
      seq_valid = $urandom_range(0, 3) != 0;
      seq_data = (idx < n) ? sa[idx] : sb[idx-n];
      start = poke && idx == n + 1;
      acc = seq_valid && sr;
      @(negedge clk);
      if (acc) idx++;
      cyc++;
    end
    start = 1'b0; seq_valid = 1'b1; seq_data = 8'hEE;
    checks++;
    if (idx != 2 * n) begin errors++; $display("FAIL %s load: accepted %0d chars, required %0d", name, idx, 2 * n); end
    if (abort > 0) begin
      repeat (abort) @(negedge clk);
      rstn = 1'b0; seq_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({sr, ov, ol, bz, dn, oa, ob} !== '0) begin
        errors++;
        $display("FAIL %s abort: rdy=%b v=%b last=%b busy=%b done=%b a=%h b=%h, required all 0", name, sr, ov, ol, bz, dn, oa, ob);
      end
      rstn = 1'b1;
      @(negedge clk);
      return;
    end
    cyc = 0;
    while (!ov && cyc < 200) begin
      checks++;
      if (sr !== 1'b0 || bz !== 1'b1) begin errors++; $display("FAIL %s dp_status: seq_ready=%b busy=%b, required 0/1", name, sr, bz); end
      @(negedge clk);
      cyc++;
    end
    seq_valid = 1'b0;
    idx = 0; cyc = 0; got_done = 0; pv = 0; pr = 1;
    pa = '0; pb = '0; pl = 0;
    while (idx < 2 * n && cyc < 400) begin
      out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = poke && idx == 0;
      if (pv && !pr) begin
        checks++;
        if ({ov, oa, ob, ol} !== {pv, pa, pb, pl}) begin
          errors++;
          $display("FAIL %s stall_hold: v=%b %h/%h last=%b, required %b %h/%h last=%b", name, ov, oa, ob, ol, pv, pa, pb, pl);
        end
      end
      if (dn) got_done++;
      if (ov && out_ready) begin
        checks++;
        if (oa !== exp_a[idx] || ob !== exp_b[idx] || ol !== (idx == 2 * n - 1)) begin
          errors++;
          $display("FAIL %s pair%0d: got %s/%s last=%b, required %s/%s last=%b", name, idx, oa, ob, ol, exp_a[idx], exp_b[idx], idx == 2 * n - 1);
        end
        idx++;
      end
      pv = ov; pr = out_ready; pa = oa; pb = ob; pl = ol;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dn) got_done++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++;
    if (idx != 2 * n) begin errors++; $display("FAIL %s pair_count: got %0d pairs, required %0d", name, idx, 2 * n); end
    checks++;
    if (got_done != 1) begin errors++; $display("FAIL %s done_pulses: got %0d, required 1", name, got_done); end
    checks++;
    if (bz !== 1'b0 || ov !== 1'b0) begin errors++; $display("FAIL %s idle_after: busy=%b out_valid=%b, required 0/0", name, bz, ov); end
`ifdef NW_SCORE_OUT_EN
    checks++;
    if (fs !== 16'(exp_sc)) begin errors++; $display("FAIL %s final_score: got %0d, required %0d", name, fs, exp_sc); end
`endif
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (r4 !== 1'b0 || r2 !== 1'b0) begin errors++; $display("FAIL reset seq_ready: got %b/%b, required 0", r4, r2); end
    checks++;
    if (v4 !== 1'b0 || v2 !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b/%b, required 0", v4, v2); end
    checks++;
    if (l4 !== 1'b0 || l2 !== 1'b0) begin errors++; $display("FAIL reset out_last: got %b/%b, required 0", l4, l2); end
    checks++;
    if (busy4 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL reset busy: got %b/%b, required 0", busy4, busy2); end
    checks++;
    if (done4 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("FAIL reset done: got %b/%b, required 0", done4, done2); end
    checks++;
    if ({a4, b4, a2, b2} !== '0) begin errors++; $display("FAIL reset out_ab: got %h %h %h %h, required 0", a4, b4, a2, b2); end
`ifdef NW_SCORE_OUT_EN
    checks++;
    if (fs4 !== '0 || fs2 !== '0) begin errors++; $display("FAIL reset final_score: got %0d/%0d, required 0", fs4, fs2); end
`endif
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_match();
    set_job(0, "ACGT", "ACGT", 1, -1, -1);
    run_job("match", 0, 0, 0);
  endtask

  task automatic test_tie();
    set_job(1, "AB", "BA", 1, -1, -1);
    run_job("tie", 0, 0, 0);
  endtask

  task automatic test_mismatch();
    set_job(0, "AAAA", "TTTT", 1, -1, -1);
    run_job("mismatch", 0, 0, 0);
  endtask

  task automatic test_backpressure();
    set_job(0, "ACGT", "ACGT", 1, -1, -1);
    run_job("backpressure", 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    set_job(1, "AB", "BA", 1, -1, -1);
    run_job("reset_mid", 0, 0, 3);
    run_job("after_reset", 0, 0, 0);
  endtask

  task automatic test_start_ignored();
    set_job(0, "GATC", "GTAC", 2, -1, -2);
    run_job("start_ignored", 1, 1, 0);
  endtask

  task automatic test_random();
    string acgt = "ACGT";
    for (int t = 0; t < 8; t++) begin
      sel = t[0]; n = sel ? 2 : 4;
      for (int i = 0; i < n; i++) begin
        sa[i] = acgt[$urandom_range(0, 3)];
        sb[i] = acgt[$urandom_range(0, 3)];
      end
      ms = $urandom_range(0, 3); mm = -$urandom_range(0, 3); gs = -$urandom_range(1, 3);
      run_job($sformatf("random%0d", t), $urandom_range(0, 1) == 1, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_tie();
    test_mismatch();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
